// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the execute path (requester 0) and the
// address/compare helper (requester 1). Only one operation is in flight at a
// time. Operands are captured, the ALU gets one cycle to settle, and the result
// is then held in a response slot until the owning requester takes it.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | arbitrate round-robin, accept one request
//  EXEC  | ALU settles on registered inputs; capture result at cycle end
//  RESP  | response held for the owner until its rsp_ready
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [OPW-1:0]   alu_control,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   input  logic             alu_underflow,
   input  logic             alu_lt,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic             rsp_err,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);
   localparam logic [OPW-1:0] OP_OR  = OPW'(3);
   localparam logic [OPW-1:0] OP_SLT = OPW'(5);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ptr;
   logic             r_owner;
   logic [OPW-1:0]   r_ctrl;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_err;

   logic [1:0]       w_grant;
   logic             w_accept;
   logic [OPW-1:0]   w_sel_op;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic             w_sel_legal;

   // Round-robin grant: a lone requester always wins; on contention the pointer decides.
   always_comb begin
      w_grant = 2'b00;
      case (req_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
         default: w_grant = 2'b00;
      endcase
   end

   // Operand mux for the winner and legality check of its op code.
   always_comb begin
      w_sel_op    = w_grant[1] ? req1_op : req0_op;
      w_sel_a     = w_grant[1] ? req1_a  : req0_a;
      w_sel_b     = w_grant[1] ? req1_b  : req0_b;
      w_sel_legal = (w_sel_op == OP_ADD) || (w_sel_op == OP_SUB) ||
                    (w_sel_op == OP_AND) || (w_sel_op == OP_OR)  ||
                    (w_sel_op == OP_SLT);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 2'b00;
      rsp_valid   = 2'b00;
      busy        = 1'b1;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            busy      = 1'b0;
            req_ready = w_grant;
            w_accept  = |(req_valid & w_grant);
            if (w_accept) w_state_nxt = EXEC;
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            rsp_valid = r_owner ? 2'b10 : 2'b01;
            if (rsp_ready[r_owner]) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture on accept; result/flag capture at the end of EXEC.
   // Illegal ops run as a neutral add and report zeros instead of the ALU output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr    <= 1'b0;
         r_owner  <= 1'b0;
         r_ctrl   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_flags  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_owner <= w_grant[1];
                  r_ptr   <= ~w_grant[1];
                  r_ctrl  <= w_sel_legal ? w_sel_op : OP_ADD;
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_err   <= ~w_sel_legal;
               end
            end
            EXEC: begin
               if (r_err) begin
                  r_result <= '0;
                  r_flags  <= '0;
               end else begin
                  r_result <= alu_result;
                  r_flags  <= {alu_lt, alu_underflow, alu_overflow, alu_zero};
               end
            end
            default: ;
         endcase
      end
   end

   assign alu_control = r_ctrl;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign rsp_result  = r_result;
   assign rsp_flags   = r_flags;
   assign rsp_err     = r_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small combinational ALU model.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero, alu_overflow, alu_underflow, alu_lt;
   logic [1:0]  rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        rsp_err, busy;

   int n_cmp = 0;
   int n_err = 0;

   alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .alu_underflow(alu_underflow), .alu_lt(alu_lt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Combinational ALU stand-in: overflow/underflow are signed out-of-range high/low.
   always_comb begin
      alu_result    = 32'd0;
      alu_overflow  = 1'b0;
      alu_underflow = 1'b0;
      case (alu_control)
         4'd0: begin
            alu_result    = alu_a + alu_b;
            alu_overflow  = ~alu_a[31] & ~alu_b[31] &  alu_result[31];
            alu_underflow =  alu_a[31] &  alu_b[31] & ~alu_result[31];
         end
         4'd1: begin
            alu_result    = alu_a - alu_b;
            alu_overflow  = ~alu_a[31] &  alu_b[31] &  alu_result[31];
            alu_underflow =  alu_a[31] & ~alu_b[31] & ~alu_result[31];
         end
         4'd2: alu_result = alu_a & alu_b;
         4'd3: alu_result = alu_a | alu_b;
         4'd5: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
      alu_lt   = $signed(alu_a) < $signed(alu_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a request pattern, check the grant, then cross the accept edge.
   // The winner drops its valid bit; a loser keeps waiting.
   task automatic do_issue(input string tag, input logic [1:0] v, input logic [1:0] g);
      req_valid = v;
      #1;
      chk({tag, " req_ready"}, 32'(req_ready), 32'(g));
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
      chk({tag, " busy exec"}, 32'(busy), 32'd1);
      chk({tag, " rsp_valid exec"}, 32'(rsp_valid), 32'd0);
   endtask

   // Check the response appearing one edge after EXEC, then complete the handshake.
   task automatic finish_rsp(input string tag, input logic [1:0] v, input logic [31:0] res,
                             input logic [3:0] fl, input logic err);
      @(posedge clk); #1;
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, " rsp_result"}, rsp_result, res);
      chk({tag, " rsp_flags"}, 32'(rsp_flags), 32'(fl));
      chk({tag, " rsp_err"}, 32'(rsp_err), 32'(err));
      rsp_ready = v;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      chk({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
      chk({tag, " busy after hs"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 2'b00; rsp_ready = 2'b00;
      req0_op = 4'd0; req1_op = 4'd0;
      req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst alu_control", 32'(alu_control), 32'd0);
      chk("rst alu_a", alu_a, 32'd0);
      chk("rst alu_b", alu_b, 32'd0);
      chk("rst rsp_result", rsp_result, 32'd0);
      chk("rst rsp_flags", 32'(rsp_flags), 32'd0);
      chk("rst rsp_err", 32'(rsp_err), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single add overflowing into the sign bit.
      req0_op = 4'd0; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
      do_issue("add", 2'b01, 2'b01);
      chk("add alu_a", alu_a, 32'h4000_0000);
      chk("add alu_control", 32'(alu_control), 32'd0);
      finish_rsp("add", 2'b01, 32'h8000_0000, 4'b0010, 1'b0);

      // Contention: pointer is 1 after the add, so force it back by a fresh reset.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      req0_op = 4'd0; req0_a = 32'hFFFF_FFF0; req0_b = 32'd2;
      req1_op = 4'd1; req1_a = 32'd2;          req1_b = 32'd1;
      do_issue("cont1", 2'b11, 2'b01);
      chk("cont1 req_ready exec", 32'(req_ready), 32'd0);
      finish_rsp("cont1", 2'b01, 32'hFFFF_FFF2, 4'b1000, 1'b0);
      do_issue("cont2", 2'b11, 2'b10);
      finish_rsp("cont2", 2'b10, 32'd1, 4'b0000, 1'b0);
      do_issue("cont3", 2'b11, 2'b01);
      finish_rsp("cont3", 2'b01, 32'hFFFF_FFF2, 4'b1000, 1'b0);
      req_valid = 2'b00;

      // Back-pressure from requester 1 while requester 0 (SLT) waits.
      req1_op = 4'd2; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
      req0_op = 4'd5; req0_a = 32'h8000_0000; req0_b = 32'd1;
      do_issue("bp", 2'b10, 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp rsp_valid", 32'(rsp_valid), 32'd2);
         chk("bp rsp_result", rsp_result, 32'd0);
         chk("bp rsp_flags", 32'(rsp_flags), 32'd1);
         chk("bp req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 2'b10;
      #1;
      chk("bp req_ready before hs", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      chk("bp rsp_valid after hs", 32'(rsp_valid), 32'd0);
      chk("bp req_ready after hs", 32'(req_ready), 32'd1);

      // The waiting SLT is accepted on the cycle after the handshake.
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("slt busy", 32'(busy), 32'd1);
      chk("slt alu_control", 32'(alu_control), 32'd5);
      finish_rsp("slt", 2'b01, 32'd1, 4'b1000, 1'b0);

      // Illegal op: runs as add internally, reports zeros with err.
      req0_op = 4'd7; req0_a = 32'd5; req0_b = 32'd3;
      do_issue("ill", 2'b01, 2'b01);
      chk("ill alu_control", 32'(alu_control), 32'd0);
      chk("ill rsp_err early", 32'(rsp_err), 32'd1);
      finish_rsp("ill", 2'b01, 32'd0, 4'b0000, 1'b1);

      // Reset in EXEC drops the transaction and returns the pointer to 0.
      req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
      do_issue("rexe", 2'b01, 2'b01);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rexe busy", 32'(busy), 32'd0);
      chk("rexe rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rexe alu_control", 32'(alu_control), 32'd0);
      chk("rexe alu_a", alu_a, 32'd0);
      chk("rexe alu_b", alu_b, 32'd0);
      chk("rexe rsp_err", 32'(rsp_err), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rexe no rsp", 32'(rsp_valid), 32'd0);
      end
      do_issue("rexe grant", 2'b11, 2'b01);
      req_valid = 2'b00;
      finish_rsp("rexe grant", 2'b01, 32'd2, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
